if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- A DEPTH-entry show-ahead FIFO of {pc, inst} pairs sitting between the IF and ID stages.
- Decouples fetch from decode with a valid/ready handshake on both sides and a single-cycle flush for branch redirect.
- An empty queue presents a zero-instruction bubble to ID, so the stall path needs no explicit bubble insertion.

Parameters:
ADDR_WIDTH, 32, width of pc field
INST_WIDTH, 32, width of instruction field
DEPTH, 4, number of entries; power of two, >= 2
CNT_WIDTH, 3, occupancy counter width; must equal log2(DEPTH)+1

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; asynchronous, active-low
if_valid  input  1  IF offers an entry this cycle
if_pc  input  ADDR_WIDTH  pc of offered instruction
if_inst  input  INST_WIDTH  offered instruction
if_ready  output  1  queue can accept an entry this cycle
id_valid  output  1  head entry present
id_pc  output  ADDR_WIDTH  pc of head entry
id_inst  output  INST_WIDTH  head instruction
id_ready  input  1  ID consumes head this cycle
flush  input  1  discard all entries (branch/jump redirect)
occupancy  output  CNT_WIDTH  current entry count, 0..DEPTH

Behaviour:
- Reset (rst low, asynchronous, any time including mid-operation):
  - wr_ptr = 0, rd_ptr = 0, count = 0 immediately.
  - Outputs follow at once: id_valid = 0, id_pc = 0, id_inst = 0, if_ready = 1, occupancy = 0.
  - Storage array contents are not reset and not observable.
- Push: the entry is written on a clk edge when if_valid && if_ready && !flush. The entry is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop: the head is removed on a clk edge when id_valid && id_ready && !flush. rd_ptr increments modulo DEPTH.
- if_ready = (count != DEPTH).
  - When full, no push is accepted, even if a pop occurs in the same cycle (no full pass-through).
- id_valid = (count != 0).
- id_pc/id_inst are combinational from the entry at rd_ptr when id_valid = 1, and 0 when id_valid = 0.
  - This gives show-ahead behaviour with zero-instruction bubble insertion.
- Latency:
  - An entry pushed at edge N is visible on id_* after edge N; no combinational IF->ID bypass.
  - Minimum IF-to-ID latency is one cycle, matching the old register.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle (0 < count < DEPTH): unchanged; both pointers advance.
- Empty: a pop is impossible because id_valid = 0; id_ready is ignored.
- Full: if_valid is ignored and if_ready = 0. A pop on the full cycle frees a slot, and if_ready rises for the next cycle.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Ordering stays strict FIFO across the wrap.
- Flush (synchronous, highest priority after reset):
  - At the edge: count = 0, wr_ptr = rd_ptr = 0.
  - Any simultaneous push or pop is discarded.
  - On the following cycle: id_valid = 0, id_inst = 0.
  - if_ready remains combinational from count, so IF may see if_ready = 1 during the flush cycle. The entry offered in that cycle is dropped; IF must re-present from the redirect pc.
- id_ready may be asserted while id_valid = 0 without effect.
- if_pc/if_inst are sampled only on an accepted push.
- occupancy = count; it is registered state and never exceeds DEPTH.

Test Plan:
1. Reset then idle:
   - Drive rst low mid-run with 3 entries queued.
   - Required: id_valid = 0, id_inst = 0, if_ready = 1 and occupancy = 0 without waiting for a clk edge.
2. Fill to full:
   - DEPTH=4, id_ready = 0; push pc 0x00, 0x04, 0x08, 0x0C.
   - Required: occupancy reaches 4 and if_ready = 0.
   - A fifth push with pc 0x10 is not stored.
   - After four pops, id_pc sequence is 0x00, 0x04, 0x08, 0x0C.
3. Streaming with wrap:
   - if_valid = id_ready = 1 continuously for 10 cycles with pc = 0x100 + 4k.
   - Required: occupancy holds at 1 after the first cycle.
   - id_pc presents 0x100..0x124 in order, each one cycle after its push; pointers wrap twice.
4. Full plus simultaneous pop:
   - At count = 4, assert if_valid and id_ready together.
   - Required: pop occurs, push is rejected, occupancy = 3.
   - if_ready = 1 on the next cycle.
5. Flush with concurrent traffic:
   - count = 2, assert flush together with if_valid (pc 0x200) and id_ready.
   - Required: next cycle occupancy = 0, id_valid = 0, id_inst = 0, and 0x200 is never presented.
   - A subsequent push of 0x300 appears as head one cycle later.
6. Empty bubble:
   - count = 0, id_ready = 1, if_valid = 0 for 3 cycles.
   - Required: id_valid = 0, id_pc = 0, id_inst = 0 throughout, and occupancy stays 0 (no underflow).

Source files
------------

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry show-ahead FIFO of {pc, inst} pairs between IF and ID.
// Replaces the single-entry IF/ID register. Valid/ready handshakes on both
// sides, and a single-cycle synchronous flush for branch/jump redirect. An
// empty queue drives zeros on id_pc/id_inst, so the stall path needs no
// explicit bubble insertion.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   if_valid   IF offers {if_pc, if_inst} this cycle
//   if_pc      pc of offered instruction
//   if_inst    offered instruction
//   if_ready   queue accepts an entry this cycle (not full)
//   id_valid   head entry present (not empty)
//   id_pc      pc of head entry, 0 when empty
//   id_inst    head instruction, 0 when empty
//   id_ready   ID consumes the head this cycle
//   flush      discard every entry and any same-cycle push/pop
//   occupancy  current entry count, 0..DEPTH

// One storage slot. Not reset: its contents are only visible through the
// head mux, which is gated by id_valid.
module if_id_queue_entry #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] d_pc,
  input  logic [INST_WIDTH-1:0] d_inst,
  output logic [ADDR_WIDTH-1:0] q_pc,
  output logic [INST_WIDTH-1:0] q_inst
);
  always_ff @(posedge clk) begin
    if (we) begin
      q_pc   <= d_pc;
      q_inst <= d_inst;
    end
  end
endmodule

module if_id_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  input  logic [INST_WIDTH-1:0] if_inst,
  output logic                  if_ready,
  output logic                  id_valid,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [INST_WIDTH-1:0] id_inst,
  input  logic                  id_ready,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  occupancy
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic                 push, pop;

  logic [DEPTH-1:0]                 ent_we;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_pc;
  logic [DEPTH-1:0][INST_WIDTH-1:0] ent_inst;

  // Full refuses a push even when a pop frees a slot in the same cycle; this
  // keeps if_ready a pure function of registered count.
  assign if_ready  = (count != CNT_WIDTH'(DEPTH));
  assign id_valid  = (count != '0);
  assign occupancy = count;

  assign push = if_valid && if_ready && !flush;
  assign pop  = id_valid && id_ready && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are log2(DEPTH) bits and wrap on overflow.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_we[i] = push && (wr_ptr == PTR_W'(i));
    if_id_queue_entry #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INST_WIDTH (INST_WIDTH)
    ) u_ent (
      .clk    (clk),
      .we     (ent_we[i]),
      .d_pc   (if_pc),
      .d_inst (if_inst),
      .q_pc   (ent_pc[i]),
      .q_inst (ent_inst[i])
    );
  end

  // Show-ahead head; zeros when empty form the bubble seen by ID.
  assign id_pc   = id_valid ? ent_pc[rd_ptr]   : '0;
  assign id_inst = id_valid ? ent_inst[rd_ptr] : '0;
endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;
  logic        flush;
  logic [2:0]  occupancy;

  int pass_cnt = 0;
  int total_cnt = 0;

  if_id_queue #(.ADDR_WIDTH(32), .INST_WIDTH(32), .DEPTH(4), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_ready(id_ready),
    .flush(flush), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hC0DE0000 | pc;
  endfunction

  // Advance one edge; outputs settle by #1 afterwards.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst_of(pc);
  endtask

  task automatic test_reset();
    rst = 1'b0; offer(1'b0, 32'h0); id_ready = 1'b0; flush = 1'b0;
    step();
    total_cnt++; if (occupancy !== 3'd0) $display("FAIL reset_occ got %0d want 0", occupancy); else pass_cnt++;
    total_cnt++; if (if_ready !== 1'b1) $display("FAIL reset_if_ready got %b want 1", if_ready); else pass_cnt++;
    rst = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      offer(1'b1, 32'h40 + 32'(4 * k));
      step();
    end
    offer(1'b0, 32'h0);
    total_cnt++; if (occupancy !== 3'd3) $display("FAIL pre_reset_occ got %0d want 3", occupancy); else pass_cnt++;
    // Assert reset mid-cycle, check before any edge.
    #2 rst = 1'b0;
    #1;
    total_cnt++; if (id_valid !== 1'b0) $display("FAIL async_rst_id_valid got %b want 0", id_valid); else pass_cnt++;
    total_cnt++; if (id_inst !== 32'h0) $display("FAIL async_rst_id_inst got %h want 0", id_inst); else pass_cnt++;
    total_cnt++; if (id_pc !== 32'h0) $display("FAIL async_rst_id_pc got %h want 0", id_pc); else pass_cnt++;
    total_cnt++; if (if_ready !== 1'b1) $display("FAIL async_rst_if_ready got %b want 1", if_ready); else pass_cnt++;
    total_cnt++; if (occupancy !== 3'd0) $display("FAIL async_rst_occ got %0d want 0", occupancy); else pass_cnt++;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_fill_full();
    id_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      offer(1'b1, 32'(4 * k));
      step();
      total_cnt++; if (occupancy !== 3'(k + 1)) $display("FAIL fill_occ%0d got %0d want %0d", k, occupancy, k + 1); else pass_cnt++;
    end
    total_cnt++; if (if_ready !== 1'b0) $display("FAIL full_if_ready got %b want 0", if_ready); else pass_cnt++;
    offer(1'b1, 32'h10);
    step();
    total_cnt++; if (occupancy !== 3'd4) $display("FAIL fifth_push_occ got %0d want 4", occupancy); else pass_cnt++;
    offer(1'b0, 32'h0);
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total_cnt++; if (id_pc !== 32'(4 * k)) $display("FAIL drain_pc%0d got %h want %h", k, id_pc, 4 * k); else pass_cnt++;
      total_cnt++; if (id_inst !== inst_of(32'(4 * k))) $display("FAIL drain_inst%0d got %h want %h", k, id_inst, inst_of(32'(4 * k))); else pass_cnt++;
      step();
    end
    total_cnt++; if (id_valid !== 1'b0) $display("FAIL drain_empty got %b want 0", id_valid); else pass_cnt++;
    id_ready = 1'b0;
  endtask

  task automatic test_stream_wrap();
    id_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        total_cnt++; if (id_pc !== 32'h100 + 32'(4 * (k - 1))) $display("FAIL stream_pc%0d got %h want %h", k, id_pc, 32'h100 + 4 * (k - 1)); else pass_cnt++;
      end
      offer(1'b1, 32'h100 + 32'(4 * k));
      step();
      total_cnt++; if (occupancy !== 3'd1) $display("FAIL stream_occ%0d got %0d want 1", k, occupancy); else pass_cnt++;
    end
    offer(1'b0, 32'h0);
    total_cnt++; if (id_pc !== 32'h124) $display("FAIL stream_last_pc got %h want 124", id_pc); else pass_cnt++;
    step();
    total_cnt++; if (id_valid !== 1'b0) $display("FAIL stream_empty got %b want 0", id_valid); else pass_cnt++;
    id_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    id_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      offer(1'b1, 32'h400 + 32'(4 * k));
      step();
    end
    offer(1'b1, 32'h500);
    id_ready = 1'b1;
    total_cnt++; if (if_ready !== 1'b0) $display("FAIL fullpop_if_ready_before got %b want 0", if_ready); else pass_cnt++;
    step();
    offer(1'b0, 32'h0);
    total_cnt++; if (occupancy !== 3'd3) $display("FAIL fullpop_occ got %0d want 3", occupancy); else pass_cnt++;
    total_cnt++; if (if_ready !== 1'b1) $display("FAIL fullpop_if_ready_after got %b want 1", if_ready); else pass_cnt++;
    for (int k = 1; k < 4; k++) begin
      total_cnt++; if (id_pc !== 32'h400 + 32'(4 * k)) $display("FAIL fullpop_pc%0d got %h want %h", k, id_pc, 32'h400 + 4 * k); else pass_cnt++;
      step();
    end
    total_cnt++; if (id_valid !== 1'b0) $display("FAIL fullpop_rejected got %b want 0", id_valid); else pass_cnt++;
    id_ready = 1'b0;
  endtask

  task automatic test_flush();
    id_ready = 1'b0;
    offer(1'b1, 32'h600); step();
    offer(1'b1, 32'h604); step();
    total_cnt++; if (occupancy !== 3'd2) $display("FAIL flush_pre_occ got %0d want 2", occupancy); else pass_cnt++;
    offer(1'b1, 32'h200); id_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; offer(1'b0, 32'h0); id_ready = 1'b0;
    total_cnt++; if (occupancy !== 3'd0) $display("FAIL flush_occ got %0d want 0", occupancy); else pass_cnt++;
    total_cnt++; if (id_valid !== 1'b0) $display("FAIL flush_id_valid got %b want 0", id_valid); else pass_cnt++;
    total_cnt++; if (id_inst !== 32'h0) $display("FAIL flush_id_inst got %h want 0", id_inst); else pass_cnt++;
    step();
    total_cnt++; if (id_valid !== 1'b0) $display("FAIL flush_dropped got %b want 0", id_valid); else pass_cnt++;
    offer(1'b1, 32'h300);
    step();
    offer(1'b0, 32'h0);
    total_cnt++; if (id_valid !== 1'b1) $display("FAIL post_flush_valid got %b want 1", id_valid); else pass_cnt++;
    total_cnt++; if (id_pc !== 32'h300) $display("FAIL post_flush_pc got %h want 300", id_pc); else pass_cnt++;
    total_cnt++; if (occupancy !== 3'd1) $display("FAIL post_flush_occ got %0d want 1", occupancy); else pass_cnt++;
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
  endtask

  task automatic test_empty_bubble();
    offer(1'b0, 32'h0);
    id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total_cnt++; if (id_valid !== 1'b0) $display("FAIL bubble_valid%0d got %b want 0", k, id_valid); else pass_cnt++;
      total_cnt++; if (id_pc !== 32'h0 || id_inst !== 32'h0) $display("FAIL bubble_data%0d got %h/%h want 0/0", k, id_pc, id_inst); else pass_cnt++;
      total_cnt++; if (occupancy !== 3'd0) $display("FAIL bubble_occ%0d got %0d want 0", k, occupancy); else pass_cnt++;
    end
    id_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_full();
    test_stream_wrap();
    test_full_pop();
    test_flush();
    test_empty_bubble();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
